// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the parametrised countdown timer and the lock/chamber
// controllers that instantiate it.
//   - ST_IDLE / ST_RUN / ST_DONE : 2-bit state encoding
//   - state_t                    : FSM state type built on that encoding
//   - CD_DEF_WIDTH / CD_DEF_COUNT: defaults matching the legacy 8-step timer
// -----------------------------------------------------------------------------
package countdown_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    localparam int CD_DEF_WIDTH = 4;
    localparam int CD_DEF_COUNT = 8;

endpackage : countdown_pkg

// File: rtl/countdown_counter.sv
// -----------------------------------------------------------------------------
// countdown_counter
// Loadable down-counter used by countdown_timer_param.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (count -> 0)
//   i_clear    : force count to 0 (highest priority)
//   i_load     : load i_load_val
//   i_dec      : decrement by one; saturates at 0
//   i_load_val : value loaded on i_load
//   o_count    : current count (registered)
//   o_is_one   : count == 1, i.e. the next decrement expires the interval
// -----------------------------------------------------------------------------
module countdown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_is_one
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            // Guard keeps the counter from wrapping even if misused.
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count  = r_count;
    assign o_is_one = (r_count == WIDTH'(1));

endmodule : countdown_counter

// File: rtl/countdown_timer_param.sv
// -----------------------------------------------------------------------------
// countdown_timer_param
// Tick-driven countdown with abort, optional auto-reload and pre-expiry warn.
// Ports:
//   i_clk         : clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_start       : begin countdown (only looked at in IDLE)
//   i_use_load    : 1 = start from i_load_val, 0 = start from DEFAULT_COUNT
//   i_load_val    : start value when i_use_load = 1
//   i_tick        : count enable
//   i_abort       : cancel; beats every other request
//   i_auto_reload : in DONE, restart from the stored reload value
//   o_count       : remaining count
//   o_busy        : state is RUN
//   o_done        : state is DONE (one-cycle pulse unless reloading zero)
//   o_warn        : RUN and 0 < count <= WARN_THRESH
// All status outputs are registered from the next-state/next-count values so
// they line up with the state and count registers.
// -----------------------------------------------------------------------------
module countdown_timer_param
    import countdown_pkg::*;
#(
    parameter int WIDTH         = CD_DEF_WIDTH,
    parameter int DEFAULT_COUNT = CD_DEF_COUNT,
    parameter int WARN_THRESH   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_use_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_tick,
    input  logic             i_abort,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_warn
);

    localparam logic [WIDTH-1:0] DEF_V  = WIDTH'(DEFAULT_COUNT);
    localparam int unsigned      WARN_U = WARN_THRESH;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_done;
    logic             r_warn;

    logic [WIDTH-1:0] w_count;
    logic             w_is_one;
    logic             w_clear;
    logic             w_load;
    logic             w_dec;
    logic [WIDTH-1:0] w_load_value;
    logic [WIDTH-1:0] w_start_val;
    logic [WIDTH-1:0] w_count_next;

    assign w_start_val = i_use_load ? i_load_val : DEF_V;

    // Next-state and counter control.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_load_value = w_start_val;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_load       = 1'b1;
                    w_load_value = w_start_val;
                    w_state_next = (w_start_val == '0) ? S_DONE : S_RUN;
                end else begin
                    w_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_clear      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (i_tick) begin
                    w_dec = 1'b1;
                    // The 1 -> 0 step always leaves RUN, so count is never 0 here.
                    if (w_is_one) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_abort) begin
                    w_clear      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (i_auto_reload) begin
                    w_load       = 1'b1;
                    w_load_value = r_reload;
                    // A zero reload value parks the timer in DONE.
                    w_state_next = (r_reload == '0) ? S_DONE : S_RUN;
                end else begin
                    w_clear      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Value the counter will hold after this edge; feeds the registered warn.
    always_comb begin
        w_count_next = w_count;
        if (w_clear) begin
            w_count_next = '0;
        end else if (w_load) begin
            w_count_next = w_load_value;
        end else if (w_dec && (w_count != '0)) begin
            w_count_next = w_count - WIDTH'(1);
        end
    end

    countdown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (w_load_value),
        .o_count    (w_count),
        .o_is_one   (w_is_one)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_reload <= DEF_V;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_warn   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Only a fresh start captures a new reload value.
            if (w_load && (r_state == S_IDLE)) begin
                r_reload <= w_load_value;
            end
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_DONE);
            r_warn <= (w_state_next == S_RUN) && (w_count_next != '0)
                      && (32'(w_count_next) <= WARN_U);
        end
    end

    assign o_count = w_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_warn  = r_warn;

endmodule : countdown_timer_param

// File: tb/tb_countdown_timer_param.sv
module tb_countdown_timer_param;

    localparam int W    = 4;
    localparam int DEFC = 8;
    localparam int WT   = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         d_start = 1'b0;
    logic         d_use_load = 1'b0;
    logic [W-1:0] d_load_val = '0;
    logic         d_tick = 1'b0;
    logic         d_abort = 1'b0;
    logic         d_auto = 1'b0;
    logic [W-1:0] o_count;
    logic         o_busy;
    logic         o_done;
    logic         o_warn;

    int total = 0;
    int bad   = 0;

    // Reference model: "phase" is 0 idle, 1 counting, 2 expired.
    int m_phase  = 0;
    int m_left   = 0;
    int m_reload = DEFC;

    always #5 clk = ~clk;

    countdown_timer_param #(
        .WIDTH         (W),
        .DEFAULT_COUNT (DEFC),
        .WARN_THRESH   (WT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (d_start),
        .i_use_load    (d_use_load),
        .i_load_val    (d_load_val),
        .i_tick        (d_tick),
        .i_abort       (d_abort),
        .i_auto_reload (d_auto),
        .o_count       (o_count),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_warn        (o_warn)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_left   = 0;
        m_reload = DEFC;
    endtask

    // Apply the interval rules for one clock edge using the current inputs.
    task automatic model_edge();
        int v;
        if (m_phase == 0) begin
            if (d_start && !d_abort) begin
                v        = d_use_load ? int'(d_load_val) : DEFC;
                m_reload = v;
                m_left   = v;
                m_phase  = (v == 0) ? 2 : 1;
            end else begin
                m_left = 0;
            end
        end else if (m_phase == 1) begin
            if (d_abort) begin
                m_phase = 0;
                m_left  = 0;
            end else if (d_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            if (d_abort || !d_auto) begin
                m_phase = 0;
                m_left  = 0;
            end else begin
                m_left  = m_reload;
                m_phase = (m_reload == 0) ? 2 : 1;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        int exp_warn;
        exp_warn = (m_phase == 1 && m_left > 0 && m_left <= WT) ? 1 : 0;
        check({ctx, ".count"}, int'(o_count), m_left);
        check({ctx, ".busy"}, int'(o_busy), (m_phase == 1) ? 1 : 0);
        check({ctx, ".done"}, int'(o_done), (m_phase == 2) ? 1 : 0);
        check({ctx, ".warn"}, int'(o_warn), exp_warn);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all(ctx);
        $display("[%0t] %s start=%0b ld=%0b lv=%0d tick=%0b abort=%0b auto=%0b -> count=%0d busy=%0b done=%0b warn=%0b",
                 $time, ctx, d_start, d_use_load, d_load_val, d_tick, d_abort, d_auto,
                 o_count, o_busy, o_done, o_warn);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int edge_done;

        // ---- reset state
        model_reset();
        repeat (2) step("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // ---- 1: default count, tick every cycle
        d_tick = 1'b1; d_use_load = 1'b0; d_start = 1'b1;
        step("t1.start");
        d_start = 1'b0;
        check("t1.first", int'(o_count), 8);
        done_cnt = 0; busy_cnt = o_busy ? 1 : 0; edge_done = -1;
        for (int i = 1; i <= 10; i++) begin
            step("t1.run");
            if (i <= 8) check("t1.seq", int'(o_count), 8 - i);
            if (o_busy) busy_cnt++;
            if (o_done) begin done_cnt++; edge_done = i; end
        end
        check("t1.done_cycles", done_cnt, 1);
        check("t1.done_edge", edge_done, 8);
        check("t1.busy_cycles", busy_cnt, 8);

        // ---- 2: load 3, tick every third cycle
        d_use_load = 1'b1; d_load_val = 4'd3; d_tick = 1'b0; d_start = 1'b1;
        step("t2.start");
        d_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            d_tick = (i % 3 == 2);
            step("t2.run");
        end
        d_tick = 1'b0;
        step("t2.tail");

        // ---- 3: zero load goes straight to DONE
        d_load_val = 4'd0; d_start = 1'b1; d_tick = 1'b1;
        step("t3.start");
        d_start = 1'b0;
        check("t3.done", int'(o_done), 1);
        step("t3.after");

        // ---- 4: abort at count 5, then restart
        d_load_val = 4'd9; d_start = 1'b1;
        step("t4.start");
        d_start = 1'b0;
        for (int i = 0; i < 20 && m_left != 5; i++) step("t4.run");
        d_abort = 1'b1;
        step("t4.abort");
        d_abort = 1'b0;
        check("t4.cleared", int'(o_count), 0);
        d_load_val = 4'd6; d_start = 1'b1;
        step("t4.restart");
        d_start = 1'b0;
        check("t4.restart_val", int'(o_count), 6);
        for (int i = 0; i < 8; i++) step("t4.run2");

        // ---- 5: auto-reload of 2, then stop reloading
        d_auto = 1'b1; d_load_val = 4'd2; d_start = 1'b1;
        step("t5.start");
        d_start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step("t5.loop");
            if (o_done) done_cnt++;
        end
        check("t5.done_pulses", done_cnt, 3);
        for (int i = 0; i < 6 && !(m_phase == 1 && m_left == 1); i++) step("t5.align");
        d_auto = 1'b0;
        step("t5.last_done");
        step("t5.to_idle");
        check("t5.idle_busy", int'(o_busy), 0);

        // ---- 6: asynchronous reset mid-run
        d_load_val = 4'd7; d_start = 1'b1;
        step("t6.start");
        d_start = 1'b0;
        step("t6.run");
        step("t6.run");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("t6.after");

        // ---- random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            d_start    = ($urandom_range(3) == 0);
            d_abort    = ($urandom_range(15) == 0);
            d_tick     = $urandom_range(1);
            d_auto     = ($urandom_range(2) == 0);
            d_use_load = $urandom_range(1);
            d_load_val = W'($urandom_range(15));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_countdown_timer_param
